// File: rtl/mux2_pkt_arbiter_if.sv
// Handshake bundle for the two-input packet arbiter: two valid/ready input
// streams (source 0 and source 1) and one merged output stream that also
// carries the source index of each beat.
interface mux2_pkt_arbiter_if #(
  parameter int DATA_W = 8
) ();
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_last;
  logic              in0_ready;

  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_last;
  logic              in1_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_src;
  logic              out_ready;

  // Driver side: produces input beats, consumes output beats.
  modport master (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_last, out_src,
    output out_ready
  );

  // Arbiter side.
  modport slave (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_last, out_src,
    input  out_ready
  );
endinterface

// File: rtl/mux2_pkt_arbiter.sv
// Two-input packet arbiter. Round-robin between source 0 and source 1 at
// packet granularity: a source that starts a multi-beat packet keeps the
// grant until its last beat is accepted. The selected beat is captured in a
// single output register (one beat of storage, full throughput when the
// consumer keeps out_ready high).
module mux2_pkt_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux2_pkt_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   lp_reg, lp_next;           // source granted at the last packet start

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_last_reg;
  logic              out_src_reg;

  // Per-source views so the selected source can be indexed by sel.
  logic [1:0]             valid;
  logic [1:0]             last;
  logic [1:0][DATA_W-1:0] data;
  logic [1:0]             ready;

  logic sel;
  logic space;
  logic acc;

  assign valid = {bus.in1_valid, bus.in0_valid};
  assign last  = {bus.in1_last,  bus.in0_last};
  assign data  = {bus.in1_data,  bus.in0_data};

  // The output register can take a beat when empty or being drained now.
  assign space = ~out_valid_reg | bus.out_ready;

  // Grant select: locked source wins; otherwise the single valid source,
  // or the source that did not win last time.
  always_comb begin
    sel = ~lp_reg;
    case (state_reg)
      LOCK0:   sel = 1'b0;
      LOCK1:   sel = 1'b1;
      default: begin
        if (valid == 2'b01)      sel = 1'b0;
        else if (valid == 2'b10) sel = 1'b1;
      end
    endcase
  end

  // Ready goes only to the selected source, and never while in reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready[gi] = rst_n & space & (sel == 1'(gi));
    end
  endgenerate

  assign bus.in0_ready = ready[0];
  assign bus.in1_ready = ready[1];

  assign acc = valid[sel] & ready[sel];

  // State and round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lp_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      lp_reg    <= lp_next;
    end
  end

  // Next state: lock on a non-final first beat, unlock on a final beat;
  // the pointer moves only when a packet starts.
  always_comb begin
    state_next = state_reg;
    lp_next    = lp_reg;
    if (acc) begin
      case (state_reg)
        IDLE: begin
          lp_next = sel;
          if (!last[sel]) state_next = sel ? LOCK1 : LOCK0;
        end
        LOCK0, LOCK1: begin
          if (last[sel]) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output register: load on accept, otherwise empty when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_src_reg   <= 1'b0;
    end else if (acc) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= data[sel];
      out_last_reg  <= last[sel];
      out_src_reg   <= sel;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_src   = out_src_reg;

endmodule

// File: doc/mux2_pkt_arbiter.md
Name: mux2_pkt_arbiter

Overview:
- Two-input packet arbiter that generates the select for a 2:1 data mux and registers the muxed result.
- Sits directly upstream of a consumer stage. It merges two valid/ready streams, source 0 and source 1, into one output stream.
- Arbitration is round-robin at packet granularity. Once a source is granted, it holds the grant until its last beat is accepted.

Parameters:
- DATA_W, 8, width of each data beat.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in0_valid  input  1  source 0 beat valid.
- in0_data  input  DATA_W  source 0 beat data.
- in0_last  input  1  source 0 beat is the final beat of its packet.
- in0_ready  output  1  source 0 beat accepted this cycle when in0_valid is also high.
- in1_valid  input  1  source 1 beat valid.
- in1_data  input  DATA_W  source 1 beat data.
- in1_last  input  1  source 1 beat is the final beat of its packet.
- in1_ready  output  1  source 1 beat accepted this cycle when in1_valid is also high.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered muxed data.
- out_last  output  1  registered last flag of the held beat.
- out_src  output  1  source index of the held beat; 0 means source 0, 1 means source 1.
- out_ready  input  1  downstream accepts the beat this cycle when out_valid is also high.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - FSM goes to IDLE; last-grant pointer lp=1, so source 0 has first priority.
  - in0_ready and in1_ready are combinationally 0 while rst_n is low.
- Output register capacity is one beat. Define space = !out_valid | out_ready.
- FSM states are IDLE, LOCK0 and LOCK1.
- Select sel is combinational:
  - LOCK0 gives sel=0; LOCK1 gives sel=1.
  - In IDLE, if exactly one source is valid, sel is that source.
  - In IDLE, if both sources are valid, sel = !lp.
  - In IDLE with no source valid, sel = !lp; no beat is accepted.
- Ready generation:
  - inN_ready = space & (sel==N).
  - The ungranted source's ready is always 0.
  - A granted source sees ready even when it is not valid.
- Accept condition: acc = in_sel_valid & in_sel_ready.
  - On acc, the output register loads data, last and src from the selected input.
  - out_valid is set to 1 on acc.
  - Otherwise, out_valid is cleared when out_ready is high.
- Latency is 1 cycle from input accept to out_valid. Sustained throughput is 1 beat/cycle when out_ready is held high.
- FSM transitions, evaluated on acc only:
  - IDLE, accepted beat with last=0: go to LOCKsel; lp is updated to sel.
  - IDLE, accepted beat with last=1: single-beat packet; stay in IDLE; lp is updated to sel.
  - LOCKn, accepted beat with last=1: go to IDLE.
  - LOCKn, accepted beat with last=0: stay in LOCKn.
  - No acc: state holds.
- While in LOCKn, the other source waits indefinitely, even if LOCKn's source drops valid mid-packet. There is no timeout.
- Round-robin order:
  - lp changes only at packet start.
  - When both sources are continuously valid with 1-beat packets, grants alternate 0,1,0,1,...
- Stall handling: if out_valid=1 and out_ready=0, the output register holds and both readys are 0. Input data is not required to be stable while not accepted.
- Simultaneous events:
  - An out_ready drain and a new acc in the same cycle replace the beat; out_valid stays 1.
  - A last beat is accepted and the arbiter returns to IDLE in the same edge. The next cycle may grant either source; no idle bubble is required.
- Mid-operation reset: an asynchronous reset during LOCKn discards the held beat and returns all state to reset values immediately.

Test Plan:
- Reset: hold rst_n=0 with both inputs valid -> out_valid=0, in0_ready=in1_ready=0. Release rst_n -> first accepted beat has out_src=0.
- Alternation: both sources valid, last=1, in0_data=0xA0 and in1_data=0xB1, out_ready=1 -> out_data sequence 0xA0,0xB1,0xA0,0xB1; one beat per cycle.
- Packet lock: source 0 sends a 3-beat packet 0x11,0x12,0x13 (last on 0x13) while source 1 is valid with 0x55 -> output 0x11,0x12,0x13, then 0x55. in1_ready stays 0 during the lock.
- Backpressure: drop out_ready for 3 cycles while a beat is held -> out_data stable, both readys 0. Raise out_ready -> the next beat appears 1 cycle after acceptance, with no loss and no duplication.
- Valid gap inside a lock: source 1 mid-packet drops valid for 2 cycles while source 0 is valid -> no source 0 beat is accepted until source 1's last beat completes.
- Reset mid-packet: assert rst_n low during LOCK1 with out_valid=1 -> out_valid=0 immediately. After release, source 0 is granted first.
